// File: rtl/fpdiv_pkg.sv
// rtl/fpdiv_pkg.sv - shared state encoding and mux select codes for the fpdiv control path
package fpdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_N,
        LOAD_D,
        ITER_A,
        ITER_B,
        REM,
        ROUND,
        DONE
    } state_t;

    localparam logic [1:0] SEL3_IA  = 2'b00;
    localparam logic [1:0] SEL3_C   = 2'b01;
    localparam logic [1:0] SEL3_REM = 2'b10;

    localparam logic [1:0] SEL4_NUM = 2'b00;
    localparam logic [1:0] SEL4_DEN = 2'b01;
    localparam logic [1:0] SEL4_A   = 2'b10;
    localparam logic [1:0] SEL4_B   = 2'b11;

endpackage

// File: rtl/fpdiv_ctrl.sv
// rtl/fpdiv_ctrl.sv - Goldschmidt divider sequencer: load, refine, remainder, round, done
import fpdiv_pkg::*;

module fpdiv_ctrl #(
    parameter int ITERS        = 5,
    parameter int ROUND_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rm_in,
    input  logic       flush,
    output logic       en_a,
    output logic       en_b,
    output logic       en_rem,
    output logic [1:0] sel_mux3,
    output logic [1:0] sel_mux4,
    output logic       rm,
    output logic       busy,
    output logic       done,
    output logic [3:0] iter_cnt
);

    if (ITERS < 1 || ITERS > 15) begin : g_bad_iters
        $error("fpdiv_ctrl: ITERS must be within 1..15");
    end
    if (ROUND_CYCLES < 1 || ROUND_CYCLES > 7) begin : g_bad_round
        $error("fpdiv_ctrl: ROUND_CYCLES must be within 1..7");
    end

    localparam logic [3:0] ITER_LAST = 4'(ITERS - 1);
    localparam logic [2:0] RND_LOAD  = 3'(ROUND_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] iter_q, iter_d;
    logic [2:0] rnd_q, rnd_d;
    logic       rm_q, rm_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
            rnd_q   <= '0;
            rm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            rnd_q   <= rnd_d;
            rm_q    <= rm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        rnd_d   = rnd_q;
        rm_d    = rm_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD_N;
                    rm_d    = rm_in;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_N: state_d = LOAD_D;
            LOAD_D: begin
                iter_d  = '0;
                state_d = ITER_A;
            end
            ITER_A: state_d = ITER_B;
            ITER_B: begin
                if (iter_q == ITER_LAST) begin
                    state_d = REM;
                end else begin
                    iter_d  = iter_q + 4'd1;
                    state_d = ITER_A;
                end
            end
            REM: begin
                rnd_d   = RND_LOAD;
                state_d = ROUND;
            end
            ROUND: begin
                if (rnd_q == '0) begin
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a start in the same cycle.
        if (flush) begin
            state_d = IDLE;
            iter_d  = iter_q;
            rnd_d   = rnd_q;
            rm_d    = rm_q;
        end
    end

    always_comb begin
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_rem   = 1'b0;
        sel_mux3 = SEL3_IA;
        sel_mux4 = SEL4_NUM;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            IDLE: busy = 1'b0;
            LOAD_N: en_a = 1'b1;
            LOAD_D: begin
                en_b     = 1'b1;
                sel_mux4 = SEL4_DEN;
            end
            ITER_A: begin
                en_a     = 1'b1;
                sel_mux3 = SEL3_C;
                sel_mux4 = SEL4_A;
            end
            ITER_B: begin
                en_b     = 1'b1;
                sel_mux3 = SEL3_C;
                sel_mux4 = SEL4_B;
            end
            REM: begin
                en_rem   = 1'b1;
                sel_mux3 = SEL3_REM;
                sel_mux4 = SEL4_A;
            end
            ROUND: begin
                sel_mux3 = SEL3_REM;
                sel_mux4 = SEL4_A;
            end
            DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                sel_mux3 = SEL3_REM;
                sel_mux4 = SEL4_A;
            end
            default: busy = 1'b0;
        endcase
    end

    assign rm       = rm_q;
    assign iter_cnt = iter_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb/tb_fpdiv_ctrl.sv - randomized scoreboard bench for fpdiv_ctrl at two parameter points
module tb_fpdiv_ctrl;

    localparam int IT0 = 5;
    localparam int RC0 = 1;
    localparam int IT1 = 1;
    localparam int RC1 = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic rm_in = 1'b0;
    logic flush = 1'b0;

    logic       en_a [2];
    logic       en_b [2];
    logic       en_rem [2];
    logic [1:0] s3 [2];
    logic [1:0] s4 [2];
    logic       rm_o [2];
    logic       busy [2];
    logic       done [2];
    logic [3:0] itc [2];

    always #5 clk = ~clk;

    fpdiv_ctrl #(.ITERS(IT0), .ROUND_CYCLES(RC0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .rm_in(rm_in), .flush(flush),
        .en_a(en_a[0]), .en_b(en_b[0]), .en_rem(en_rem[0]),
        .sel_mux3(s3[0]), .sel_mux4(s4[0]), .rm(rm_o[0]),
        .busy(busy[0]), .done(done[0]), .iter_cnt(itc[0])
    );

    fpdiv_ctrl #(.ITERS(IT1), .ROUND_CYCLES(RC1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .rm_in(rm_in), .flush(flush),
        .en_a(en_a[1]), .en_b(en_b[1]), .en_rem(en_rem[1]),
        .sel_mux3(s3[1]), .sel_mux4(s4[1]), .rm(rm_o[1]),
        .busy(busy[1]), .done(done[1]), .iter_cnt(itc[1])
    );

    function automatic int iters_of(int g);
        return (g == 0) ? IT0 : IT1;
    endfunction

    // One operation: two loads, ITERS pairs, remainder, rounds, done.
    function automatic int oplen(int g);
        return 2 + 2 * iters_of(g) + 1 + ((g == 0) ? RC0 : RC1) + 1;
    endfunction

    bit act [2];
    int pos [2];
    bit mrm [2];
    int cyc = 0;
    int sbq0 [$];
    int sbq1 [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < 2; g++) begin
                act[g] <= 1'b0;
                pos[g] <= 0;
                mrm[g] <= 1'b0;
            end
            sbq0.delete();
            sbq1.delete();
        end else begin
            cyc <= cyc + 1;
            for (int g = 0; g < 2; g++) begin
                if (flush) begin
                    act[g] <= 1'b0;
                    if (g == 0) sbq0.delete(); else sbq1.delete();
                end else if (act[g] && pos[g] < oplen(g) - 1) begin
                    pos[g] <= pos[g] + 1;
                end else if (start) begin
                    act[g] <= 1'b1;
                    pos[g] <= 0;
                    mrm[g] <= rm_in;
                    if (g == 0) sbq0.push_back((cyc + oplen(g)) * 2 + int'(rm_in));
                    else        sbq1.push_back((cyc + oplen(g)) * 2 + int'(rm_in));
                end else begin
                    act[g] <= 1'b0;
                end
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int g, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s inst%0d cyc=%0d got=%0d want=%0d", name, g, cyc, got, want);
        end
    endtask

    always begin
        @(negedge clk or negedge reset_n);
        #1;
        for (int g = 0; g < 2; g++) begin
            int it, ln, p, e, qs, front;
            int ea, eb, er, e3, e4, ebusy, edone;
            bit chk_sel;
            it = iters_of(g);
            ln = oplen(g);
            p = pos[g];
            ea = 0; eb = 0; er = 0; e3 = 0; e4 = 0; ebusy = 0; edone = 0;
            chk_sel = 1'b1;
            if (act[g]) begin
                ebusy = (p < ln - 1) ? 1 : 0;
                if (p == 0) begin
                    ea = 1;
                end else if (p == 1) begin
                    eb = 1; e4 = 1;
                end else if (p < 2 + 2 * it) begin
                    e3 = 1;
                    if ((p - 2) % 2 == 0) begin ea = 1; e4 = 2; end
                    else begin eb = 1; e4 = 3; end
                end else if (p == 2 + 2 * it) begin
                    er = 1; e3 = 2; e4 = 2;
                end else if (p < ln - 1) begin
                    e3 = 2; e4 = 2;
                end else begin
                    edone = 1; chk_sel = 1'b0;
                end
            end
            check("en_a", g, int'(en_a[g]), ea);
            check("en_b", g, int'(en_b[g]), eb);
            check("en_rem", g, int'(en_rem[g]), er);
            check("busy", g, int'(busy[g]), ebusy);
            check("done", g, int'(done[g]), edone);
            check("rm", g, int'(rm_o[g]), int'(mrm[g]));
            check("onehot", g, int'(en_a[g]) + int'(en_b[g]) + int'(en_rem[g]) <= 1 ? 1 : 0, 1);
            check("iter_max", g, int'(itc[g]) <= it - 1 ? 1 : 0, 1);
            if (chk_sel) begin
                check("sel_mux3", g, int'(s3[g]), e3);
                check("sel_mux4", g, int'(s4[g]), e4);
            end
            if (!reset_n) check("iter_rst", g, int'(itc[g]), 0);
            else if (act[g] && p >= 2 && p < 2 + 2 * it) check("iter_cnt", g, int'(itc[g]), (p - 2) / 2);

            qs = (g == 0) ? sbq0.size() : sbq1.size();
            if (done[g]) begin
                if (qs == 0) begin
                    check("done_spurious", g, int'(done[g]), 0);
                end else begin
                    e = (g == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    check("done_cycle", g, cyc, e / 2);
                    check("done_rm", g, int'(rm_o[g]), e % 2);
                end
            end else if (qs > 0) begin
                front = (g == 0) ? sbq0[0] : sbq1[0];
                if (front / 2 < cyc) begin
                    check("done_missing", g, cyc, front / 2);
                    if (g == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(2);

        rm_in = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0; rm_in = 1'b0;
        step(20);

        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rm_in = 1'($urandom);
            step(1);
        end
        start = 1'b0;
        step(20);

        start = 1'b1; rm_in = 1'b0;
        step(1);
        start = 1'b0;
        step(6);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(2);
        start = 1'b1; rm_in = 1'b1;
        step(1);
        start = 1'b0;
        step(20);

        rm_in = 1'b0; start = 1'b1; flush = 1'b1;
        step(1);
        start = 1'b0; flush = 1'b0;
        step(3);

        start = 1'b1; rm_in = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (!(act[0] && pos[0] >= 2 && pos[0] < 2 + 2 * IT0 && (pos[0] - 2) % 2 == 1) && n < 40) begin
            step(1);
            n++;
        end
        if (n >= 40) begin
            $display("FAIL wait_iter_b timeout after %0d cycles", n);
            $fatal(1, "timeout");
        end
        #1 reset_n = 1'b0;
        #5 reset_n = 1'b1;
        step(20);

        for (int i = 0; i < 400; i++) begin
            start = ($urandom % 4) == 0;
            flush = ($urandom % 30) == 0;
            rm_in = 1'($urandom);
            step(1);
        end
        start = 1'b0; flush = 1'b0;
        step(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
